// File: rtl/simple_proc_pkg.sv
// Shared encodings for the simple_proc issue sequencer: opcodes, branch
// condition codes, FSM states and instruction field positions.
package simple_proc_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_ORR   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_MOVI  = 4'd6;
  localparam logic [3:0] OP_MOV   = 4'd7;
  localparam logic [3:0] OP_LSR   = 4'd8;
  localparam logic [3:0] OP_LSL   = 4'd9;
  localparam logic [3:0] OP_ROR   = 4'd10;
  localparam logic [3:0] OP_CMP   = 4'd11;
  localparam logic [3:0] OP_ADR   = 4'd12;
  localparam logic [3:0] OP_BCOND = 4'd13;
  localparam logic [3:0] OP_NOP   = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // The ALU treats 4'b1110 as "result 0, flags held" -- the idle opcode.
  localparam logic [3:0] ALU_NOP  = 4'b1110;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  localparam int OP_LSB   = 12;
  localparam int RD_LSB   = 9;
  localparam int RS1_LSB  = 6;
  localparam int RS2_LSB  = 3;
  localparam int IMM_LSB  = 0;
  localparam int COND_LSB = 8;
  localparam int OFF_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  function automatic logic op_writes_rd(input logic [3:0] op);
    return (op <= OP_ADR) && (op != OP_CMP);
  endfunction

endpackage

// File: rtl/simple_proc_cond_eval.sv
// Branch condition evaluator: maps a condition code and the ALU's NZCV
// flags to a taken/not-taken decision.
module simple_proc_cond_eval
  import simple_proc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = z;
      CC_NE:   taken = !z;
      CC_CS:   taken = c;
      CC_CC:   taken = !c;
      CC_MI:   taken = n;
      CC_PL:   taken = !n;
      CC_VS:   taken = v;
      CC_VC:   taken = !v;
      CC_HI:   taken = c && !z;
      CC_LS:   taken = !c || z;
      CC_GE:   taken = (n == v);
      CC_LT:   taken = (n != v);
      CC_GT:   taken = !z && (n == v);
      CC_LE:   taken = z || (n != v);
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/simple_proc_issue.sv
// Instruction sequencer in front of simple_proc_alu: fetch, decode, drive the
// ALU, write back its registered result, and resolve conditional branches.
module simple_proc_issue
  import simple_proc_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  START_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  // imem handshake: imem_req stays high in FETCH until a cycle with
  // imem_valid=1; that cycle's imem_rdata is captured on the same edge.
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [3:0]        alu_opcode,
  output logic [6:0]        alu_immediate_offset,
  output logic [15:0]       alu_operand_1,
  output logic [15:0]       alu_operand_2,
  input  logic [15:0]       alu_result,
  input  logic              alu_overflow,
  input  logic              alu_carry,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic [2:0]        dbg_addr,
  output logic [15:0]       dbg_data,
  output logic [2:0]        dbg_state,
  output logic              halted,
  output logic [15:0]       retired
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       retired_q, retired_d;
  logic [15:0]       regs_q [8];
  logic              wb_we;

  logic [3:0]        op;
  logic [2:0]        rd, rs1, rs2;
  logic [6:0]        imm7;
  logic [3:0]        cond;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] pc_inc;
  logic              br_taken;

  assign op     = ir_q[OP_LSB +: 4];
  assign rd     = ir_q[RD_LSB +: 3];
  assign rs1    = ir_q[RS1_LSB +: 3];
  assign rs2    = ir_q[RS2_LSB +: 3];
  assign imm7   = ir_q[IMM_LSB +: 7];
  assign cond   = ir_q[COND_LSB +: 4];
  // Branch offset is relative to the branch's own address; pc wraps.
  assign br_off = ADDR_W'($signed(ir_q[OFF_LSB +: 8]));
  assign pc_inc = pc_q + ADDR_W'(1);

  simple_proc_cond_eval u_cond_eval (
    .cond  (cond),
    .n     (alu_negative),
    .z     (alu_zero),
    .c     (alu_carry),
    .v     (alu_overflow),
    .taken (br_taken)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    wb_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op <= OP_ADR) begin
          state_d = ST_WB;
        end else begin
          retired_d = retired_q + 16'd1;
          state_d   = ST_FETCH;
          if (op == OP_BCOND)    pc_d = br_taken ? (pc_q + br_off) : pc_inc;
          else if (op == OP_NOP) pc_d = pc_inc;
          else                   state_d = ST_HALT;
        end
      end
      ST_WB: begin
        wb_we     = op_writes_rd(op);
        pc_d      = pc_inc;
        retired_d = retired_q + 16'd1;
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_PC;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[rd] <= alu_result;
    end
  end

  // ALU inputs are live only in EXEC; branches, NOP and HALT keep the ALU
  // idle so the flags a branch tests are not disturbed.
  always_comb begin
    alu_opcode           = ALU_NOP;
    alu_immediate_offset = '0;
    alu_operand_1        = '0;
    alu_operand_2        = '0;
    if (state_q == ST_EXEC) begin
      case (op)
        OP_ADD, OP_SUB, OP_MUL, OP_ORR, OP_AND, OP_XOR, OP_CMP: begin
          alu_opcode    = op;
          alu_operand_1 = regs_q[rs1];
          alu_operand_2 = regs_q[rs2];
        end
        OP_MOVI, OP_ADR: begin
          alu_opcode           = op;
          alu_immediate_offset = imm7;
        end
        OP_MOV: begin
          alu_opcode    = op;
          alu_operand_1 = regs_q[rs1];
        end
        OP_LSR, OP_LSL, OP_ROR: begin
          alu_opcode           = op;
          alu_operand_1        = regs_q[rd];
          alu_immediate_offset = imm7;
        end
        default: alu_opcode = ALU_NOP;
      endcase
    end
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign retired   = retired_q;
  assign dbg_data  = regs_q[dbg_addr];
  assign dbg_state = state_q;

endmodule
